// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, 2-entry skid buffer, flush.
// Optional stall counter port stall_cycles enabled by PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_SKID
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

    // Handshake flags are registered next to the state so in_ready never
    // depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_main      <= RESET_VAL;
            r_skid      <= RESET_VAL;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main      <= in_data;
                        r_state     <= S_FULL;
                        r_out_valid <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main <= in_data;
                    end else if (w_in_xfer) begin
                        r_skid     <= in_data;
                        r_state    <= S_SKID;
                        r_in_ready <= 1'b0;
                    end else if (w_out_xfer) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                S_SKID: begin
                    if (w_out_xfer) begin
                        r_main     <= r_skid;
                        r_state    <= S_FULL;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;

    assign stall_cycles = r_stall_cnt;

    // Saturating; flush deliberately leaves the count alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table, corner sequences, random vs queue model.
module tb_pipe_stage_reg;

    localparam int          W  = 16;
    localparam logic [15:0] RV = 16'hA5A5;
`ifdef PIPE_STAGE_REG_PERF_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef PIPE_STAGE_REG_PERF_EN
    logic [CW-1:0] stall_cycles;
`endif

    pipe_stage_reg #(
        .WIDTH    (W),
        .RESET_VAL(RV),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef PIPE_STAGE_REG_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: the stage is a FIFO of depth 2 whose head is the output.
    logic [W-1:0] mq[$];
    int           mcnt = 0;

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         orr;
        logic         eov;
        logic         eir;
        logic [W-1:0] eod;
        logic         cd;
    } vec_t;

    vec_t vt[24];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [W-1:0] d, input logic orr);
        bit pop;
        bit push;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = orr;
        pop  = (mq.size() > 0) && orr;
        push = iv && (mq.size() < 2);
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (mq.size() > 0 && !orr && mcnt < (1 << CW) - 1) mcnt++;
            if (fl) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(d);
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ov"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, "_ir"}, 32'(in_ready), 32'(mq.size() < 2));
        if (mq.size() > 0) chk({tag, "_od"}, 32'(out_data), 32'(mq[0]));
`ifdef PIPE_STAGE_REG_PERF_EN
        chk({tag, "_stall"}, 32'(stall_cycles), 32'(mcnt));
`endif
    endtask

    initial begin
        bit           stalled;
        logic [W-1:0] prev;
        logic         r_rst;
        logic         r_fl;
        logic         r_or;

        // Streaming: 0x1234 then 0x0001..0x0010 at full rate.
        vt[0] = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1};
        for (int i = 1; i <= 16; i++)
            vt[i] = '{1'b1, 16'(i), 1'b1, 1'b1, 1'b1, 16'(i), 1'b1};
        vt[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
        // Backpressure into SKID, C refused, then drain A,B,C.
        vt[18] = '{1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b1, 16'hAAAA, 1'b1};
        vt[19] = '{1'b1, 16'hBBBB, 1'b0, 1'b1, 1'b0, 16'hAAAA, 1'b1};
        vt[20] = '{1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b0, 16'hAAAA, 1'b1};
        vt[21] = '{1'b1, 16'hCCCC, 1'b1, 1'b1, 1'b1, 16'hBBBB, 1'b1};
        vt[22] = '{1'b1, 16'hCCCC, 1'b1, 1'b1, 1'b1, 16'hCCCC, 1'b1};
        vt[23] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};

        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_ir", 32'(in_ready), 32'd1);
        chk("rst_od", 32'(out_data), 32'(RV));
`ifdef PIPE_STAGE_REG_PERF_EN
        chk("rst_stall", 32'(stall_cycles), 32'd0);
`endif

        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b0, vt[i].iv, vt[i].d, vt[i].orr);
            chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vt[i].eov));
            chk($sformatf("vec%0d_ir", i), 32'(in_ready), 32'(vt[i].eir));
            if (vt[i].cd)
                chk($sformatf("vec%0d_od", i), 32'(out_data), 32'(vt[i].eod));
        end

        // Flush from SKID with a concurrent input that must be dropped.
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h1111, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h2222, 1'b0);
        chk("skid_ir", 32'(in_ready), 32'd0);
        step(1'b0, 1'b1, 1'b1, 16'h5555, 1'b0);
        chk("flush_ov", 32'(out_valid), 32'd0);
        chk("flush_ir", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, '0, 1'b1);
            chk($sformatf("flush_after%0d_ov", i), 32'(out_valid), 32'd0);
        end

        // Reset while FULL; next item has 1-cycle latency.
        step(1'b0, 1'b0, 1'b1, 16'h7777, 1'b0);
        chk("full_od", 32'(out_data), 32'h7777);
        step(1'b1, 1'b0, 1'b1, 16'h9999, 1'b0);
        chk("midrst_ov", 32'(out_valid), 32'd0);
        chk("midrst_od", 32'(out_data), 32'(RV));
        chk("midrst_ir", 32'(in_ready), 32'd1);
        step(1'b0, 1'b0, 1'b1, 16'h4242, 1'b1);
        chk("postrst_ov", 32'(out_valid), 32'd1);
        chk("postrst_od", 32'(out_data), 32'h4242);

`ifdef PIPE_STAGE_REG_PERF_EN
        // Stall counter saturation, flush immunity, reset clear.
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h3333, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("stall_sat", 32'(stall_cycles), 32'd15);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("stall_flush", 32'(stall_cycles), 32'd15);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("stall_rst", 32'(stall_cycles), 32'd0);
`endif

        // Random traffic against the FIFO model.
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int c = 0; c < 10000; c++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_fl  = ($urandom_range(0, 49) == 0);
            r_or  = 1'($urandom_range(0, 1));
            stalled = out_valid && !r_or && !r_rst && !r_fl;
            prev = out_data;
            step(r_rst, r_fl, 1'($urandom_range(0, 1)),
                 16'($urandom), r_or);
            check_model($sformatf("rnd%0d", c));
            if (stalled)
                chk($sformatf("rnd%0d_stable", c), 32'(out_data), 32'(prev));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
